// File: rtl/sel_rr_scheduler_if.sv
// Request/grant bundle between the requesters and the round-robin
// path scheduler.
interface sel_rr_scheduler_if #(
  parameter int LIMIT = 4
);
  localparam int N = LIMIT * 4;

  logic [N-1:0]     req;
  logic             done;
  logic [LIMIT-1:0] select;
  logic [N-1:0]     path;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  select,
    input  path,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output select,
    output path,
    output busy,
    output timeout
  );
endinterface

// File: rtl/sel_rr_scheduler.sv
// Round-robin owner scheduler for a shared 4-to-16 path selector.
// Define SEL_HOLD_TIMEOUT_EN to enable the HOLD_MAX ownership limit.
module sel_rr_scheduler #(
  parameter int LIMIT    = 4,
  parameter int HOLD_MAX = 8
) (
  input logic           clk1,
  input logic           rst,
  sel_rr_scheduler_if.slave bus
);
  localparam int N = LIMIT * 4;

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  if (LIMIT != 4 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_cfg
    $error("sel_rr_scheduler: unsupported LIMIT or HOLD_MAX");
  end

  state_t           state;
  state_t           nxt;
  logic [LIMIT-1:0] select;
  logic [LIMIT-1:0] last;
  logic [LIMIT-1:0] win;
  logic [LIMIT-1:0] idx;
  logic [N-1:0]     path;
  logic             timeout;
  logic             found;
  logic             rel;
  logic             tmo_nxt;
  logic             tmo_hit;

`ifdef SEL_HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign tmo_hit = (hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Scan from last+1 upward; offset N wraps back to last itself.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = last + LIMIT'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt     = state;
    rel     = 1'b0;
    tmo_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) nxt = OWN;
      end
      OWN: begin
        if (bus.done) begin
          rel = 1'b1;
        end else if (!bus.req[select]) begin
          rel = 1'b1;
        end else if (tmo_hit) begin
          rel     = 1'b1;
          tmo_nxt = 1'b1;
        end
        if (rel) nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy    = (state == OWN);
    bus.select  = select;
    bus.path    = path;
    bus.timeout = timeout;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      select  <= '0;
      path    <= '0;
      timeout <= 1'b0;
      last    <= '1;
    end else begin
      timeout <= tmo_nxt;
      unique case (state)
        IDLE: begin
          if (found) begin
            select <= win;
            path   <= {{(N-1){1'b0}}, 1'b1} << win;
          end
        end
        OWN: begin
          if (rel) begin
            path <= '0;
            last <= select;
          end
        end
      endcase
    end
  end

`ifdef SEL_HOLD_TIMEOUT_EN
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != 8'hFF) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sel_rr_scheduler.sv
// Directed self-checking bench for sel_rr_scheduler.
module tb_sel_rr_scheduler;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  sel_rr_scheduler_if #(.LIMIT(4)) bus ();

  sel_rr_scheduler #(
    .LIMIT(4),
    .HOLD_MAX(8)
  ) dut (
    .clk1(clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_own(input string tag, input int g);
    logic [15:0] one;
    one = 16'h1 << g;
    chk({tag, ".path"}, 32'(bus.path), 32'(one));
    chk({tag, ".sel"}, 32'(bus.select), 32'(g));
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag, input int s);
    chk({tag, ".path"}, 32'(bus.path), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".sel"}, 32'(bus.select), 32'(s));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    step();
    step();
    chk_idle("rst", 0);
    chk("rst.tmo", 32'(bus.timeout), 32'd0);
    rst = 1'b0;

    // single request, then done
    bus.req = 16'h0001;
    step();
    chk_own("single", 0);
    bus.done = 1'b1;
    step();
    chk_idle("single_rel", 0);
    bus.done = 1'b0;
    bus.req  = '0;
    step();

    // restart so requester 0 leads the fairness sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 16'hFFFF;
    for (int i = 0; i <= 16; i++) begin
      step();
      chk_own($sformatf("rr%0d", i), i % 16);
      bus.done = 1'b1;
      step();
      chk_idle($sformatf("rr%0d_gap", i), i % 16);
      bus.done = 1'b0;
      if (i == 16) bus.req = 16'h8001;
    end

    // last=0: 15 is ahead of 0
    step();
    chk_own("pri15", 15);
    bus.done = 1'b1;
    step();
    chk_idle("pri15_rel", 15);
    bus.done = 1'b0;
    step();
    chk_own("pri0", 0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 16'h0010;

    // ownership limit
    step();
`ifdef SEL_HOLD_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      chk_own($sformatf("hold%0d", c), 4);
      chk($sformatf("hold%0d.tmo", c), 32'(bus.timeout), 32'd0);
      step();
    end
    chk_idle("tmo_rel", 4);
    chk("tmo_pulse", 32'(bus.timeout), 32'd1);
    step();
    chk("tmo_clear", 32'(bus.timeout), 32'd0);
    chk_own("tmo_regrant", 4);
    bus.req = '0;
    step();
`else
    for (int c = 0; c < 20; c++) begin
      chk_own($sformatf("hold%0d", c), 4);
      chk($sformatf("hold%0d.tmo", c), 32'(bus.timeout), 32'd0);
      step();
    end
    bus.req = '0;
    step();
`endif
    chk_idle("drop_rel", 4);
    chk("drop_rel.tmo", 32'(bus.timeout), 32'd0);

    // done coincides with last allowed cycle
    bus.req = 16'h0010;
    step();
    chk_own("sim_grant", 4);
    for (int c = 0; c < 7; c++) step();
    bus.done = 1'b1;
    step();
    chk_idle("sim_rel", 4);
    chk("sim_rel.tmo", 32'(bus.timeout), 32'd0);
    bus.done = 1'b0;
    bus.req  = '0;
    step();

    // request drop mid-hold
    bus.req = 16'h0020;
    step();
    chk_own("mid_grant", 5);
    step();
    step();
    bus.req = '0;
    step();
    chk_idle("mid_rel", 5);

    // asynchronous reset during ownership
    bus.req = 16'h0400;
    step();
    chk_own("pre_rst", 10);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst", 0);
    chk("async_rst.tmo", 32'(bus.timeout), 32'd0);
    step();
    rst = 1'b0;
    bus.req = 16'h0401;
    step();
    chk_own("post_rst", 0);
    bus.req = 16'h0400;
    step();
    chk_idle("post_rst_rel", 0);
    step();
    chk_own("post_rst10", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
